// File: rtl/lynx_kbd_pkg.sv
// Shared types, scancode constants and the PS/2 set-2 to Lynx keymap.
// Imported by lynx_keymap and lynx_kbd_matrix.
package lynx_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } kbd_state_e;

  localparam logic [7:0] SC_E0  = 8'hE0;
  localparam logic [7:0] SC_E1  = 8'hE1;
  localparam logic [7:0] SC_F0  = 8'hF0;
  localparam logic [7:0] SC_F12 = 8'h07;

  // Extended codes that also feed the joystick
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_CTRL  = 8'h14;

  localparam logic [2:0] SKIP_LEN  = 3'd7;
  localparam logic [3:0] SHIFT_ROW = 4'd0;
  localparam logic [2:0] SHIFT_COL = 3'd0;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
    logic       shift_valid;
    logic [3:0] shift_row;
    logic [2:0] shift_col;
  } keymap_t;

  function automatic keymap_t km(
    input logic [3:0] r,
    input logic [2:0] c
  );
    keymap_t e;
    e = '0;
    e.valid = 1'b1;
    e.row   = r;
    e.col   = c;
    return e;
  endfunction

  // Symbols the Lynx only produces with SHIFT held
  function automatic keymap_t kms(
    input logic [3:0] r,
    input logic [2:0] c
  );
    keymap_t e;
    e = km(r, c);
    e.shift_valid = 1'b1;
    e.shift_row   = SHIFT_ROW;
    e.shift_col   = SHIFT_COL;
    return e;
  endfunction

  function automatic keymap_t keymap_lookup(
    input logic       ext,
    input logic [7:0] code
  );
    keymap_t e;
    e = '0;
    case ({ext, code})
      9'h012: e = km(4'd0, 3'd0);
      9'h059: e = km(4'd0, 3'd0);
      9'h076: e = km(4'd0, 3'd1);
      9'h016: e = km(4'd0, 3'd2);
      9'h014: e = km(4'd0, 3'd3);
      9'h114: e = km(4'd0, 3'd3);
      9'h058: e = km(4'd0, 3'd4);
      9'h01E: e = km(4'd1, 3'd0);
      9'h026: e = km(4'd1, 3'd1);
      9'h024: e = km(4'd1, 3'd2);
      9'h01D: e = km(4'd1, 3'd3);
      9'h015: e = km(4'd1, 3'd4);
      9'h025: e = km(4'd2, 3'd0);
      9'h02D: e = km(4'd2, 3'd1);
      9'h01B: e = km(4'd2, 3'd2);
      9'h01C: e = km(4'd2, 3'd3);
      9'h022: e = km(4'd2, 3'd4);
      9'h01A: e = km(4'd2, 3'd5);
      9'h02E: e = km(4'd3, 3'd0);
      9'h02C: e = km(4'd3, 3'd1);
      9'h023: e = km(4'd3, 3'd2);
      9'h02B: e = km(4'd3, 3'd3);
      9'h021: e = km(4'd3, 3'd4);
      9'h02A: e = km(4'd3, 3'd5);
      9'h036: e = km(4'd4, 3'd0);
      9'h035: e = km(4'd4, 3'd1);
      9'h034: e = km(4'd4, 3'd2);
      9'h033: e = km(4'd4, 3'd3);
      9'h032: e = km(4'd4, 3'd4);
      9'h031: e = km(4'd4, 3'd5);
      9'h03D: e = km(4'd5, 3'd0);
      9'h03E: e = km(4'd5, 3'd1);
      9'h03C: e = km(4'd5, 3'd2);
      9'h043: e = km(4'd5, 3'd3);
      9'h03B: e = km(4'd5, 3'd4);
      9'h03A: e = km(4'd5, 3'd5);
      9'h046: e = km(4'd6, 3'd0);
      9'h044: e = km(4'd6, 3'd1);
      9'h042: e = km(4'd6, 3'd2);
      9'h04B: e = km(4'd6, 3'd3);
      9'h041: e = km(4'd6, 3'd4);
      9'h049: e = km(4'd6, 3'd5);
      9'h052: e = kms(4'd6, 3'd6);
      9'h045: e = km(4'd7, 3'd0);
      9'h04D: e = km(4'd7, 3'd1);
      9'h04E: e = km(4'd7, 3'd2);
      9'h055: e = kms(4'd7, 3'd2);
      9'h04C: e = km(4'd7, 3'd3);
      9'h04A: e = km(4'd7, 3'd4);
      9'h066: e = km(4'd8, 3'd0);
      9'h054: e = km(4'd8, 3'd1);
      9'h05B: e = km(4'd8, 3'd2);
      9'h05A: e = km(4'd8, 3'd3);
      9'h15A: e = km(4'd8, 3'd3);
      9'h00D: e = km(4'd8, 3'd4);
      9'h175: e = km(4'd9, 3'd0);
      9'h172: e = km(4'd9, 3'd1);
      9'h16B: e = km(4'd9, 3'd2);
      9'h029: e = km(4'd9, 3'd3);
      9'h174: e = km(4'd9, 3'd4);
      9'h171: e = km(4'd9, 3'd5);
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lynx_keymap.sv
// Combinational PS/2 set-2 to Lynx matrix position lookup.
// Ports: ext_i (E0 prefix seen), code_i (scancode), entry_o (keymap entry).
module lynx_keymap
  import lynx_kbd_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output keymap_t    entry_o
);

  always_comb begin
    entry_o = keymap_lookup(ext_i, code_i);
  end

endmodule

// File: rtl/lynx_kbd_matrix.sv
// PS/2 set-2 decoder driving a Camputers Lynx keyboard matrix.
// Ports: clk, reset (sync, active-high), kbd_intr/kbd_scancode (byte
// strobe), row_sel/row_data (matrix read), kbd_reset (F12 held),
// kbd_joy {fire,up,down,left,right}. Joystick built with LYNX_KBD_JOY_EN.
module lynx_kbd_matrix
  import lynx_kbd_pkg::*;
#(
  parameter int NUM_ROWS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbd_intr,
  input  logic [7:0] kbd_scancode,
  input  logic [3:0] row_sel,
  output logic [7:0] row_data,
  output logic       kbd_reset,
  output logic [4:0] kbd_joy
);

  kbd_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;

  logic make_ev;
  logic brk_ev;
  logic ext_ev;
  logic is_e0;
  logic is_e1;
  logic is_f0;

  keymap_t ent;

  logic [NUM_ROWS-1:0][7:0] mat_q, mat_d;
  logic [7:0] rd_q, rd_d;
  logic       rst_key_q, rst_key_d;

  assign is_e0 = (kbd_scancode == SC_E0);
  assign is_e1 = (kbd_scancode == SC_E1);
  assign is_f0 = (kbd_scancode == SC_F0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (kbd_intr) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (1'b1)
            is_e0: state_d = ST_EXT;
            is_f0: state_d = ST_BRK;
            is_e1: begin
              state_d = ST_SKIP;
              skip_d  = SKIP_LEN;
            end
            default: state_d = ST_IDLE;
          endcase
        end
        ST_EXT: begin
          unique case (1'b1)
            is_f0:   state_d = ST_EXT_BRK;
            is_e0:   state_d = ST_EXT;
            default: state_d = ST_IDLE;
          endcase
        end
        ST_BRK:     state_d = ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            state_d = ST_IDLE;
            skip_d  = 3'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Event outputs
  always_comb begin
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ext_ev  = 1'b0;
    if (kbd_intr) begin
      unique case (state_q)
        ST_IDLE:
          make_ev = !(is_e0 || is_f0 || is_e1);
        ST_EXT: begin
          make_ev = !(is_e0 || is_f0);
          ext_ev  = make_ev;
        end
        ST_BRK:
          brk_ev = 1'b1;
        ST_EXT_BRK: begin
          brk_ev = 1'b1;
          ext_ev = 1'b1;
        end
        default: ;
      endcase
    end
  end

  lynx_keymap u_keymap (
    .ext_i   (ext_ev),
    .code_i  (kbd_scancode),
    .entry_o (ent)
  );

  // Make clears a bit (active-low), break sets it
  always_comb begin
    mat_d = mat_q;
    if ((make_ev || brk_ev) && ent.valid) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < 8; c++) begin
          if (ent.row == 4'(r) && ent.col == 3'(c))
            mat_d[r][c] = brk_ev;
          if (ent.shift_valid &&
              ent.shift_row == 4'(r) &&
              ent.shift_col == 3'(c))
            mat_d[r][c] = brk_ev;
        end
      end
    end
  end

  always_comb begin
    rd_d = 8'hFF;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_sel == 4'(r))
        rd_d = mat_q[r];
    end
  end

  always_comb begin
    rst_key_d = rst_key_q;
    if (!ext_ev && kbd_scancode == SC_F12) begin
      if (make_ev) rst_key_d = 1'b1;
      if (brk_ev)  rst_key_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mat_q     <= '1;
      rd_q      <= 8'hFF;
      rst_key_q <= 1'b0;
    end else begin
      mat_q     <= mat_d;
      rd_q      <= rd_d;
      rst_key_q <= rst_key_d;
    end
  end

  assign row_data  = rd_q;
  assign kbd_reset = rst_key_q;

`ifdef LYNX_KBD_JOY_EN
  logic [4:0] joy_q, joy_d;

  always_comb begin
    joy_d = joy_q;
    if (ext_ev) begin
      case (kbd_scancode)
        SC_CTRL:  joy_d[4] = make_ev;
        SC_UP:    joy_d[3] = make_ev;
        SC_DOWN:  joy_d[2] = make_ev;
        SC_LEFT:  joy_d[1] = make_ev;
        SC_RIGHT: joy_d[0] = make_ev;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) joy_q <= 5'b0;
    else       joy_q <= joy_d;
  end

  assign kbd_joy = joy_q;
`else
  assign kbd_joy = 5'b0;
`endif

endmodule

// File: doc/lynx_kbd_matrix.md
LYNX_KBD_MATRIX -- requirements
Module: lynx_kbd_matrix

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 10: number of Lynx keyboard matrix rows.
REQ-002 SHALL have port clk, input, 1 bit: system clock. This is the single clock domain.
REQ-003 SHALL have port reset, input, 1 bit: synchronous reset, active-high.
REQ-004 SHALL have port kbd_intr, input, 1 bit: one-cycle strobe, asserted when a new PS/2 byte is valid.
REQ-005 SHALL have port kbd_scancode, input, 8 bits: PS/2 set-2 byte, valid only when kbd_intr=1.
REQ-006 SHALL have port row_sel, input, 4 bits: matrix row index driven by the core's keyboard port decode.
REQ-007 SHALL have port row_data, output, 8 bits: active-low column state of the selected row.
REQ-008 SHALL have port kbd_reset, output, 1 bit: high while F12 (0x07) is held.
REQ-009 SHALL have port kbd_joy, output, 5 bits: {fire, up, down, left, right}, active-high.

Function
REQ-010 SHALL sample kbd_scancode only on cycles where kbd_intr=1; all other cycles SHALL leave the decoder state unchanged.
REQ-011 SHALL implement a prefix FSM with states IDLE, EXT, BRK, EXT_BRK and SKIP.
REQ-012 IDLE transitions: 0xE0 -> EXT; 0xF0 -> BRK; 0xE1 -> SKIP with skip counter = 7; any other byte -> make-event, stay in IDLE.
REQ-013 EXT transitions: 0xF0 -> EXT_BRK; 0xE0 -> stay in EXT; any other byte -> extended make-event, go to IDLE.
REQ-014 BRK transitions: any byte -> break-event, go to IDLE.
REQ-015 EXT_BRK transitions: any byte -> extended break-event, go to IDLE.
REQ-016 SKIP: each strobe SHALL decrement the 3-bit counter; on the strobe where the counter reaches 0 the FSM SHALL return to IDLE; no events are generated in SKIP.
REQ-017 A make-event SHALL clear the mapped (row, col) bit; a break-event SHALL set it. The update SHALL be visible the cycle after the strobe.
REQ-018 An unmapped code SHALL cause no matrix change; the FSM SHALL still advance normally.
REQ-019 One scancode SHALL map to at most two matrix positions (e.g. shifted symbols also drive SHIFT). Both bits SHALL update on the same cycle.
REQ-020 row_data SHALL be registered: row_data = matrix[row_sel], one cycle of latency.
REQ-021 row_sel >= NUM_ROWS SHALL give row_data = 8'hFF.
REQ-022 A repeated make-event (typematic) for a held key SHALL be idempotent.
REQ-023 kbd_reset SHALL follow the F12 make/break state. It is registered and is not a pulse.

Reset
REQ-024 On reset: every matrix bit = 1, row_data = 8'hFF, kbd_reset = 0, kbd_joy = 0, FSM = IDLE, skip counter = 0.
REQ-025 Reset SHALL abort any prefix or SKIP sequence in progress. A kbd_intr that coincides with reset SHALL be ignored.

Configuration
REQ-026 Macro LYNX_KBD_JOY_EN: when defined, the extended arrow keys (E0 75/72/6B/74) SHALL drive up/down/left/right, and Right-Ctrl (E0 14) SHALL drive fire, on kbd_joy. These keys SHALL also still drive their matrix positions.
REQ-027 When LYNX_KBD_JOY_EN is not defined, kbd_joy SHALL be the constant 5'b0 and no joystick registers SHALL be synthesised.

Structure
REQ-028 Package lynx_kbd_pkg SHALL hold: the FSM state enum, the scancode constants (E0, E1, F0, F12), the keymap entry typedef {valid, row[3:0], col[2:0], shift_valid, shift_row, shift_col}, and the keymap table.
REQ-029 The package keymap table SHALL include: 0x1C (A) -> row 2 col 3; 0x29 (Space) -> row 9 col 3; 0x12 (L-Shift) -> row 0 col 0; 0x5A (Return) -> row 8 col 3.
REQ-030 The design SHALL have one sub-module, lynx_keymap: a combinational lookup from (extended, scancode) to the keymap entry.

Verification
REQ-031 Scenario: strobe 0x1C; next cycle row_sel=2 -> row_data=8'hF7 one cycle later. Then strobe F0,1C -> row_data=8'hFF.
REQ-032 Scenario: strobe E0,75 with LYNX_KBD_JOY_EN -> kbd_joy=5'b01000. Then strobe E0,F0,75 -> kbd_joy=0. Without the macro -> kbd_joy stays 0.
REQ-033 Scenario: strobe the Pause sequence E1,14,77,E1,F0,14,F0,77, then 0x29 -> only row 9 = 8'hF7; all other rows = 8'hFF.
REQ-034 Scenario: strobe 0x1C, then 0x29, then F0,1C -> row 2 = 8'hFF and row 9 = 8'hF7 (Space still held).
REQ-035 Scenario: strobe 0x07 -> kbd_reset=1. Assert reset for 1 cycle -> kbd_reset=0 and every row = 8'hFF.
REQ-036 Scenario: row_sel=4'hF with keys held -> row_data=8'hFF. Strobe 0x1C and 0x1C again -> row 2 = 8'hF7, no toggle.
